// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification, retry and fail sequencing
// Moore FSM on refclk; outputs are registered from the next-state decode so they track the state register.
module pll_reset_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [2:0] S_PLLRST   = 3'd0;
  localparam logic [2:0] S_WAITLOCK = 3'd1;
  localparam logic [2:0] S_STABLE   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_FAIL     = 3'd4;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  // The lock_s sample that moves WAITLOCK into STABLE is the first of the LOCK_STABLE run.
  localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE > 1) ? (LOCK_STABLE - 2) : 0);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic          r_sync1;
  logic          r_lock_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    w_next;
  logic [3:0]    w_retry_next;

  always_comb begin
    w_next       = r_state;
    w_retry_next = retry_cnt;
    case (r_state)
      S_PLLRST: begin
        if (r_cnt == RST_LAST) w_next = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (r_lock_s) begin
          w_next = S_STABLE;
        end else if (r_cnt == TO_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            w_retry_next = retry_cnt + 4'd1;
            w_next       = S_PLLRST;
          end else begin
            w_next = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!r_lock_s) w_next = S_WAITLOCK;
        else if (r_cnt == STB_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_lock_s) w_next = S_PLLRST;
      end
      S_FAIL: begin
        w_next = S_FAIL;
      end
      default: begin
        w_next = S_PLLRST;
      end
    endcase
    if (w_next == S_RUN) w_retry_next = 4'd0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_lock_s  <= 1'b0;
      r_state   <= S_PLLRST;
      r_cnt     <= '0;
      retry_cnt <= 4'd0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      r_sync1   <= locked;
      r_lock_s  <= r_sync1;
      r_state   <= w_next;
      retry_cnt <= w_retry_next;
      // Saturate rather than wrap while parked in RUN or FAIL.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
      pll_rst   <= (w_next == S_PLLRST) || (w_next == S_FAIL);
      sys_reset <= (w_next != S_RUN);
      ready     <= (w_next == S_RUN);
      fail      <= (w_next == S_FAIL);
      lock_lost <= (r_state == S_RUN) && (w_next == S_PLLRST);
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed bench for pll_reset_seq
// Cycle n is the refclk period following the n-th rising edge after rst release; sampling and driving at falling edges.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pll_reset_seq #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (2)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_reset(sys_reset),
    .ready    (ready),
    .fail     (fail),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge refclk);
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   pll_rst,   1);
    chk({tag, "_sys_reset"}, sys_reset, 1);
    chk({tag, "_ready"},     ready,     0);
    chk({tag, "_fail"},      fail,      0);
    chk({tag, "_lock_lost"}, lock_lost, 0);
    chk({tag, "_retry_cnt"}, retry_cnt, 0);
  endtask

  always @(negedge refclk) begin
    if (!rst && ready) begin
      n_tests++;
      assert (!sys_reset && !pll_rst) else begin
        n_fail++;
        $error("FAIL ready_excl: observed sys_reset=%0b pll_rst=%0b expected 0/0", sys_reset, pll_rst);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    locked = 1'b0;

    // Clean lock then loss in RUN
    do_reset();
    chk_reset_vals("rst0");
    go_to(3);  chk("clean_pllrst_c3", pll_rst, 1);
    go_to(4);  chk("clean_pllrst_c4", pll_rst, 0); chk("clean_sysrst_c4", sys_reset, 1);
    go_to(10); locked = 1'b1;
    go_to(19); chk("clean_ready_c19", ready, 0);
    go_to(20); chk("clean_ready_c20", ready, 1); chk("clean_sysrst_c20", sys_reset, 0);
    chk("clean_pllrst_c20", pll_rst, 0); chk("clean_retry_c20", retry_cnt, 0);
    go_to(30); locked = 1'b0;
    go_to(32); chk("loss_ready_c32", ready, 1); chk("loss_ll_c32", lock_lost, 0);
    go_to(33); chk("loss_ll_c33", lock_lost, 1); chk("loss_ready_c33", ready, 0);
    chk("loss_sysrst_c33", sys_reset, 1); chk("loss_pllrst_c33", pll_rst, 1);
    go_to(34); chk("loss_ll_c34", lock_lost, 0); chk("loss_pllrst_c34", pll_rst, 1);
    go_to(36); chk("loss_pllrst_c36", pll_rst, 1);
    go_to(37); chk("loss_pllrst_c37", pll_rst, 0); chk("loss_retry_c37", retry_cnt, 0);

    // Glitch during STABLE: locked high for cycles 10..14
    do_reset();
    go_to(10); locked = 1'b1;
    for (int k = 11; k <= 30; k++) begin
      go_to(k);
      if (k == 15) locked = 1'b0;
      chk("glitch_ready", ready, 0);
    end
    chk("glitch_retry_c30", retry_cnt, 0);
    go_to(49); chk("glitch_pllrst_c49", pll_rst, 0); chk("glitch_retry_c49", retry_cnt, 0);
    go_to(50); chk("glitch_pllrst_c50", pll_rst, 1); chk("glitch_retry_c50", retry_cnt, 1);

    // Lock first seen in the timeout cycle (counter 31, cycle 35)
    do_reset();
    go_to(33); locked = 1'b1;
    go_to(36); chk("bnd_pllrst_c36", pll_rst, 0); chk("bnd_retry_c36", retry_cnt, 0);
    go_to(42); chk("bnd_ready_c42", ready, 0);
    go_to(43); chk("bnd_ready_c43", ready, 1); chk("bnd_retry_c43", retry_cnt, 0);

    // No lock: retries then FAIL
    do_reset();
    go_to(1);   chk("nl_pllrst_c1", pll_rst, 1);
    go_to(35);  chk("nl_pllrst_c35", pll_rst, 0); chk("nl_retry_c35", retry_cnt, 0);
    go_to(36);  chk("nl_pllrst_c36", pll_rst, 1); chk("nl_retry_c36", retry_cnt, 1);
    go_to(39);  chk("nl_pllrst_c39", pll_rst, 1);
    go_to(40);  chk("nl_pllrst_c40", pll_rst, 0);
    go_to(72);  chk("nl_pllrst_c72", pll_rst, 1); chk("nl_retry_c72", retry_cnt, 2);
    go_to(76);  chk("nl_pllrst_c76", pll_rst, 0);
    go_to(107); chk("nl_fail_c107", fail, 0); chk("nl_pllrst_c107", pll_rst, 0);
    go_to(108); chk("nl_fail_c108", fail, 1); chk("nl_pllrst_c108", pll_rst, 1);
    chk("nl_retry_c108", retry_cnt, 2); chk("nl_sysrst_c108", sys_reset, 1); chk("nl_ready_c108", ready, 0);
    go_to(110); locked = 1'b1;
    go_to(130); chk("nl_fail_c130", fail, 1); chk("nl_pllrst_c130", pll_rst, 1); chk("nl_ready_c130", ready, 0);

    // Async reset from FAIL, checked before the next rising edge
    locked = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst_fail");
    @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
    go_to(3); chk("arst_fail_pllrst_c3", pll_rst, 1);
    go_to(4); chk("arst_fail_pllrst_c4", pll_rst, 0);

    // Async reset mid-STABLE, locked kept high across it
    do_reset();
    go_to(10); locked = 1'b1;
    go_to(16); chk("arst_stb_pre_sysrst", sys_reset, 1); chk("arst_stb_pre_pllrst", pll_rst, 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("arst_stb");
    @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
    go_to(3);  chk("arst_stb_pllrst_c3", pll_rst, 1);
    go_to(4);  chk("arst_stb_pllrst_c4", pll_rst, 0);
    go_to(11); chk("arst_stb_ready_c11", ready, 0);
    go_to(12); chk("arst_stb_ready_c12", ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
